// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path (and the matching transmitter).
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_mode_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} rx_state_t;

    localparam int RX_ERR_BREAK  = 0;
    localparam int RX_ERR_PARITY = 1;
    localparam int RX_ERR_FRAME  = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle Tick every DIV clocks, phase reset by Clear.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    output logic Tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign Tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
        end else if (Clear || Tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver: synchronizer, majority-vote bit FSM, and a single-entry holding register
// with overrun detection and RTS flow control.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic [1:0]           Cfg_Parity,
    input  logic                 Cfg_Stop2,
    input  logic                 Pop_Data,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    output logic                 Overrun,
    output logic                 Rx_Busy,
    output logic                 RTS
);

    localparam int DIV = (SYSCLK_RATE + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_oversampled: clock too slow for BAUD_RATE*OVERSAMPLE");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx_oversampled: DATA_BITS out of range");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_oversampled: OVERSAMPLE must be even and >= 4");
    end

    logic rx_meta, rx_sync, rx_last;
    logic tick, start_edge, voted, at_vote, at_end, par_en, par_exp, is_break;

    rx_state_t            state;
    parity_mode_t         par_mode;
    logic [SW-1:0]        smp_cnt;
    logic                 smp0, smp1;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx, stop2;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, par_err, frm_err;
    logic                 wr;
    logic [DATA_BITS-1:0] wr_data;
    logic [2:0]           wr_err, done_err, brk_err;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_last <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_last <= rx_sync;
        end
    end

    assign start_edge = (state == IDLE) && rx_last && !rx_sync;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clear (start_edge),
        .Tick  (tick)
    );

    assign voted    = majority3(smp0, smp1, rx_sync);
    assign at_vote  = tick && (smp_cnt == S_HI);
    assign at_end   = tick && (smp_cnt == S_END);
    assign par_en   = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
    assign par_exp  = (par_mode == PAR_ODD) ? ~^shreg : ^shreg;
    assign is_break = (shreg == '0) && (!par_en || !par_bit) && !voted;

    always_comb begin
        done_err                = '0;
        done_err[RX_ERR_PARITY] = par_err;
        done_err[RX_ERR_FRAME]  = frm_err | ~voted;
        brk_err                 = '0;
        brk_err[RX_ERR_BREAK]   = 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            par_mode <= PAR_NONE;
            smp_cnt  <= '0;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            stop2    <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            wr       <= 1'b0;
            wr_data  <= '0;
            wr_err   <= '0;
            Rx_Busy  <= 1'b0;
        end else begin
            wr <= 1'b0;
            if (state != IDLE && tick) begin
                smp_cnt <= at_end ? '0 : smp_cnt + 1'b1;
                if (smp_cnt == S_LO)  smp0 <= rx_sync;
                if (smp_cnt == S_MID) smp1 <= rx_sync;
            end
            case (state)
                IDLE: begin
                    smp_cnt <= '0;
                    if (start_edge) begin
                        state    <= START;
                        Rx_Busy  <= 1'b1;
                        par_mode <= parity_mode_t'(Cfg_Parity);
                        stop2    <= Cfg_Stop2;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        par_bit  <= 1'b0;
                        par_err  <= 1'b0;
                        frm_err  <= 1'b0;
                    end
                end
                START: begin
                    if (at_vote && voted) begin
                        state   <= IDLE;
                        Rx_Busy <= 1'b0;
                    end else if (at_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (at_vote) shreg <= {voted, shreg[DATA_BITS-1:1]};
                    if (at_end) begin
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            state <= par_en ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (at_vote) begin
                        par_bit <= voted;
                        par_err <= (voted != par_exp);
                    end
                    if (at_end) state <= STOP;
                end
                STOP: begin
                    if (at_vote) begin
                        if (!stop_idx && is_break) begin
                            wr      <= 1'b1;
                            wr_data <= '0;
                            wr_err  <= brk_err;
                            state   <= BREAK_WAIT;
                        end else if (stop_idx == stop2) begin
                            wr      <= 1'b1;
                            wr_data <= shreg;
                            wr_err  <= done_err;
                            state   <= IDLE;
                            Rx_Busy <= 1'b0;
                        end else begin
                            frm_err <= frm_err | ~voted;
                        end
                    end
                    if (at_end) stop_idx <= 1'b1;
                end
                BREAK_WAIT: begin
                    if (rx_sync) begin
                        state   <= IDLE;
                        Rx_Busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Rx_Busy <= 1'b0;
                end
            endcase
        end
    end

    // A pop in the same cycle as a write makes room, so the new word is never an overrun.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Data_Out <= '0;
            Rx_Error <= '0;
            Data_Rdy <= 1'b0;
            Overrun  <= 1'b0;
            RTS      <= 1'b1;
        end else if (wr) begin
            if (!Data_Rdy || Pop_Data) begin
                Data_Out <= wr_data;
                Rx_Error <= wr_err;
                Data_Rdy <= 1'b1;
                RTS      <= 1'b0;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Pop_Data && Data_Rdy) begin
            Data_Rdy <= 1'b0;
            RTS      <= 1'b1;
            Overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_oversampled;

    localparam int BT = 16;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Rx;
    logic [1:0] Cfg_Parity;
    logic       Cfg_Stop2;
    logic       Pop_Data;
    logic [7:0] Data_Out;
    logic       Data_Rdy;
    logic [2:0] Rx_Error;
    logic       Overrun;
    logic       Rx_Busy;
    logic       RTS;

    int n_chk  = 0;
    int n_fail = 0;

    logic [10:0] exp_word;

    uart_rx_oversampled #(
        .SYSCLK_RATE (1600),
        .BAUD_RATE   (100),
        .DATA_BITS   (8),
        .OVERSAMPLE  (16)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Rx         (Rx),
        .Cfg_Parity (Cfg_Parity),
        .Cfg_Stop2  (Cfg_Stop2),
        .Pop_Data   (Pop_Data),
        .Data_Out   (Data_Out),
        .Data_Rdy   (Data_Rdy),
        .Rx_Error   (Rx_Error),
        .Overrun    (Overrun),
        .Rx_Busy    (Rx_Busy),
        .RTS        (RTS)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {Rx_Error, Data_Out} from the frame's line content alone.
    function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] mode,
                                          input logic s2, input logic flip,
                                          input logic st1, input logic st2);
        logic pen, pbit, perr, ferr;
        pen  = (mode == 2'd1) || (mode == 2'd2);
        pbit = ((mode == 2'd2) ? ~^d : ^d) ^ flip;
        if (d == 8'h00 && (!pen || !pbit) && !st1) return {3'b001, 8'h00};
        perr = pen && flip;
        ferr = !st1 || (s2 && !st2);
        return {ferr, perr, 1'b0, d};
    endfunction

    task automatic line_bit(input logic b);
        Rx = b;
        repeat (BT) @(negedge Clk);
    endtask

    // Sends one frame, scrambling the config mid-frame, then idles for two bit times.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic s2,
                              input logic flip, input logic st1, input logic st2);
        logic pbit;
        pbit       = ((mode == 2'd2) ? ~^d : ^d) ^ flip;
        Cfg_Parity = mode;
        Cfg_Stop2  = s2;
        line_bit(1'b0);
        Cfg_Parity = 2'($urandom);
        Cfg_Stop2  = 1'($urandom);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        if (mode == 2'd1 || mode == 2'd2) line_bit(pbit);
        line_bit(st1);
        if (s2) line_bit(st2);
        line_bit(1'b1);
        line_bit(1'b1);
        exp_word = model(d, mode, s2, flip, st1, st2);
    endtask

    task automatic check_word(input string tag);
        chk({tag, ".data"}, 32'(Data_Out), 32'(exp_word[7:0]));
        chk({tag, ".err"}, 32'(Rx_Error), 32'(exp_word[10:8]));
        chk({tag, ".rdy"}, 32'(Data_Rdy), 32'd1);
        chk({tag, ".rts"}, 32'(RTS), 32'd0);
    endtask

    task automatic pop();
        Pop_Data = 1'b1;
        @(negedge Clk);
        Pop_Data = 1'b0;
    endtask

    initial begin
        Rst        = 1'b1;
        Rx         = 1'b1;
        Pop_Data   = 1'b0;
        Cfg_Parity = 2'd0;
        Cfg_Stop2  = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst.data", 32'(Data_Out), 32'd0);
        chk("rst.err", 32'(Rx_Error), 32'd0);
        chk("rst.rdy", 32'(Data_Rdy), 32'd0);
        chk("rst.ovr", 32'(Overrun), 32'd0);
        chk("rst.busy", 32'(Rx_Busy), 32'd0);
        chk("rst.rts", 32'(RTS), 32'd1);

        send_frame(8'hA5, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_word("a5_even");
        chk("a5.busy", 32'(Rx_Busy), 32'd0);
        pop();
        chk("a5.pop_rdy", 32'(Data_Rdy), 32'd0);
        chk("a5.pop_rts", 32'(RTS), 32'd1);

        send_frame(8'hAA, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        check_word("aa_parerr");
        pop();
        send_frame(8'h00, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        check_word("00_odd");
        pop();

        send_frame(8'h55, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_word("55_frmerr");
        pop();
        send_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_word("3c_clean");
        pop();

        Cfg_Parity = 2'd0;
        Cfg_Stop2  = 1'b0;
        Rx = 1'b0;
        repeat (12 * BT) @(negedge Clk);
        Rx = 1'b1;
        repeat (2 * BT) @(negedge Clk);
        exp_word = {3'b001, 8'h00};
        check_word("break");
        pop();
        repeat (4 * BT) @(negedge Clk);
        chk("break.single", 32'(Data_Rdy), 32'd0);
        send_frame(8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_word("81_after_break");
        pop();

        send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr.data", 32'(Data_Out), 32'h11);
        chk("ovr.flag", 32'(Overrun), 32'd1);
        chk("ovr.rdy", 32'(Data_Rdy), 32'd1);
        pop();
        chk("ovr.pop_flag", 32'(Overrun), 32'd0);
        chk("ovr.pop_rdy", 32'(Data_Rdy), 32'd0);

        Rx = 1'b0;
        repeat (4) @(negedge Clk);
        Rx = 1'b1;
        chk("glitch.busy_hi", 32'(Rx_Busy), 32'd1);
        repeat (2 * BT) @(negedge Clk);
        chk("glitch.busy_lo", 32'(Rx_Busy), 32'd0);
        chk("glitch.rdy", 32'(Data_Rdy), 32'd0);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            send_frame(d, 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0));
            check_word($sformatf("rand%0d", k));
            pop();
            chk($sformatf("rand%0d.pop", k), 32'(Data_Rdy), 32'd0);
        end

        send_frame(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("midrst.pre_rdy", 32'(Data_Rdy), 32'd1);
        Rx = 1'b0;
        repeat (5 * BT) @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("midrst.data", 32'(Data_Out), 32'd0);
        chk("midrst.err", 32'(Rx_Error), 32'd0);
        chk("midrst.rdy", 32'(Data_Rdy), 32'd0);
        chk("midrst.ovr", 32'(Overrun), 32'd0);
        chk("midrst.busy", 32'(Rx_Busy), 32'd0);
        chk("midrst.rts", 32'(RTS), 32'd1);
        Rx = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (4 * BT) @(negedge Clk);
        chk("midrst.after_rdy", 32'(Data_Rdy), 32'd0);
        chk("midrst.after_busy", 32'(Rx_Busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Parametrised UART receiver front end. It converts the asynchronous Rx line into validated data words, using oversampled majority-vote bit sampling, a runtime-selectable parity mode, and 1 or 2 stop bits. Each received word is presented with a break/parity/frame error vector through a single-entry holding register with Pop_Data acknowledge, overrun flagging and RTS flow control. It sits between the Rx pin and the receive FIFO.

Parameters:
SYSCLK_RATE, 100000000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in baud.
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, oversample ticks per bit; even and >= 4.
DIV (localparam), round(SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE)), clocks per tick; elaboration error if < 1.

Ports:
Clk  in  1  system clock; all logic on posedge.
Rst  in  1  asynchronous, active-high reset.
Rx  in  1  asynchronous serial input; idle high.
Cfg_Parity  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
Cfg_Stop2  in  1  0 = one stop bit, 1 = two stop bits.
Pop_Data  in  1  consumer acknowledge; frees the holding register.
Data_Out  out  DATA_BITS  received word, LSB first on the line.
Data_Rdy  out  1  holding register valid.
Rx_Error  out  3  [0] break, [1] parity, [2] frame; qualified by Data_Rdy.
Overrun  out  1  sticky: a word was lost because the holding register was full.
Rx_Busy  out  1  high from start-bit detection until return to IDLE.
RTS  out  1  high when the holding register is free.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high on Rst.
- Reset values: Data_Out=0, Rx_Error=0, Data_Rdy=0, Overrun=0, Rx_Busy=0, RTS=1, state=IDLE. Both synchronizer flops reset to 1.
- Input sync: Rx passes through a 2-flop synchronizer (2-cycle latency); the FSM uses only the synchronized value.
- Tick generator: counter 0..DIV-1 produces a 1-cycle tick. It is cleared on start-edge detection so bit phase aligns to the edge. The tick counter (0..OVERSAMPLE-1) counts ticks within each bit.
- Majority vote: samples are taken at tick OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three, evaluated at tick OVERSAMPLE/2+1.
- Config latch: Cfg_Parity and Cfg_Stop2 are latched at start detection. Changes mid-frame do not affect the current frame.
- IDLE: a synchronized 1->0 transition moves to START and sets Rx_Busy=1.
- START: if the voted start bit is 1, it is a false start: go to IDLE with no word written.
- DATA: shift in DATA_BITS voted bits, LSB first. Then go to PARITY if parity is enabled, otherwise STOP.
- PARITY: expected bit = ^data (even) or ~^data (odd). A mismatch sets the parity error.
- STOP: one or two stop bits are voted. Any stop bit voted 0 sets the frame error.
- Completion: on the tick that votes the last stop bit, go to IDLE and write the holding register on the next cycle.
- Break: all data bits 0, parity bit 0 (if enabled) and first stop bit 0 are reported as Data_Out=0, Rx_Error=3'b001. Parity and frame error bits are suppressed.
- BREAK_WAIT: after a break, the FSM stays here until synchronized Rx=1, then goes to IDLE. Exactly one word is produced per break.
- Write, holding register empty: Data_Rdy=1, and RTS=0 in the same cycle.
- Write while Data_Rdy=1 and Pop_Data=0: the new word is discarded, the old word is retained, Overrun is set.
- Pop_Data=1 and a write in the same cycle: the new word loads and Data_Rdy stays 1; no overrun.
- Pop_Data with no write: Data_Rdy=0, RTS=1 next cycle, Overrun cleared.
- Pop_Data while Data_Rdy=0: ignored.
- Rx_Busy: low in IDLE, high in all other states.
- Reset mid-frame: immediate return to reset values. Any partial word is lost.
- Per-bit duration: exactly DIV*OVERSAMPLE clocks. No drift correction within a frame.

Decomposition:
- Package uart_pkg: parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD); rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT); constants RX_ERR_BREAK=0, RX_ERR_PARITY=1, RX_ERR_FRAME=2.
- Sub-module uart_baud_tick: parameter DIV, inputs Clk/Rst/Clear, output Tick. It is reusable by the transmitter.

Test Plan:
All scenarios use SYSCLK_RATE=1600, BAUD_RATE=100, OVERSAMPLE=16 (DIV=1).
- Word 0xA5, even parity, 2 stop bits -> Data_Out=8'hA5, Rx_Error=3'b000, Data_Rdy=1, RTS=0; Pop_Data -> Data_Rdy=0, RTS=1.
- Word 0xAA, even parity, parity bit inverted -> Rx_Error=3'b010, Data_Out=8'hAA; odd mode with 0x00 and parity bit 1 -> Rx_Error=3'b000.
- Word 0x55 with stop bit driven 0, Rx then high -> Rx_Error=3'b100. Next frame 0x3C -> Rx_Error=3'b000, Data_Out=8'h3C.
- Rx held low for 12 bit times, then high -> exactly one word, Data_Out=0, Rx_Error=3'b001. A following 0x81 frame is received cleanly.
- Two frames 0x11, 0x22 with no Pop_Data -> Data_Out=8'h11, Overrun=1; Pop_Data -> Overrun=0, Data_Rdy=0.
- Rx low pulse of 4 clocks (< half bit) -> no Data_Rdy, Rx_Busy returns to 0. Asserting Rst mid-frame -> all outputs at reset values.
